fetch_controller: RTL and testbench
===================================

# fetch_controller

Sequences the instruction-fetch datapath: owns the program counter, computes the next PC, and drives the single port of the instruction memory (`prgrom`). Arbitrates that port between the core's fetch path and the UART program loader. During a load the core is frozen; when the load ends, the core restarts from the reset vector. Sits between the decode/ALU stage (branch, zero, offsets, stall) and the instruction memory.

## Interface
- `ADDR_W`, 14: instruction-memory word-address width (byte PC bits [ADDR_W+1:2])
- `RESET_PC`, 32'h0000_0000: reset/restart vector
- `clk` input 1: single clock, all state on posedge
- `reset` input 1: asynchronous, active-high
- `stall` input 1: hold PC and current instruction
- `branch` input 1: conditional branch in current instruction
- `zero` input 1: ALU zero flag
- `branch_offset` input 32: byte offset added to PC on taken branch
- `jump` input 1: unconditional jump
- `jump_target` input 32: absolute byte target
- `load_req` input 1: loader requests the memory port
- `load_we` input 1: loader write strobe (valid only while `load_gnt`=1)
- `load_addr` input ADDR_W: loader word address
- `load_data` input 32: loader write data
- `load_gnt` output 1: loader owns the memory port
- `mem_addr` output ADDR_W: memory word address
- `mem_we` output 1: memory write enable
- `mem_wdata` output 32: memory write data
- `mem_rdata` input 32: memory read data, one-cycle synchronous latency
- `pc` output 32: byte address of `instr`
- `instr` output 32: current instruction (= `mem_rdata`)
- `instr_valid` output 1: `instr`/`pc` are valid for the core

## Operation
- **States:** IDLE, RUN, LOAD, RESTART.
- **IDLE** (entered on reset): `mem_addr` = `RESET_PC[ADDR_W+1:2]`; next state is RUN. In RUN, `pc` = `RESET_PC`.
- **Next-PC priority in RUN** (stall > jump > taken branch > sequential):
  - stall: next = `pc`
  - jump: next = `jump_target`
  - `branch && zero`: next = `pc + branch_offset`
  - otherwise: next = `pc + 4`
  - All sums are 32-bit and wrap modulo 2^32.
  - Bits [1:0] of every next PC are forced to 0.
- **Fetch addressing in RUN:** `mem_addr` = next-PC word bits, combinational. Because the memory has one-cycle read latency, `mem_rdata` in the following cycle corresponds to the registered `pc`. There is no wrong-path instruction.
- **Stall:** during stall, `mem_addr` re-reads `pc`, so `instr` stays stable.
- **Load entry:** `load_req`=1 while in RUN (checked every cycle; it overrides stall/branch) moves the FSM to LOAD. The PC update in that cycle is suppressed.
- **LOAD:**
  - `load_gnt`=1 and `instr_valid`=0.
  - `mem_addr` = `load_addr`, `mem_we` = `load_we`, `mem_wdata` = `load_data`.
  - `pc` is held.
  - Core inputs are ignored.
- **Load exit:** `load_req`=0 while in LOAD moves the FSM to RESTART.
- **RESTART:**
  - `load_gnt`=0, `mem_we`=0, `instr_valid`=0.
  - `mem_addr` = `RESET_PC` word address; `pc` <= `RESET_PC`.
  - Next state is RUN, or LOAD if `load_req` has been re-asserted.
- **Outside LOAD:** `mem_we`=0 and `mem_wdata`=0.

## Timing
- **Reset values (asynchronous):** state=IDLE, `pc`=`RESET_PC`, `instr_valid`=0, `load_gnt`=0, `mem_we`=0, `mem_wdata`=0, `mem_addr`=`RESET_PC` word address.
- **Fetch latency:** after reset deasserts, first `instr_valid`=1 comes 1 cycle later (IDLE→RUN), with `pc`=`RESET_PC`.
- **Redirect:** a taken branch or jump in cycle N gives `pc`=target with valid `instr` in cycle N+1. The penalty is 0 cycles.
- **Grant latency:** `load_gnt` rises 1 cycle after `load_req` rises and falls 1 cycle after `load_req` falls.
- **Restart latency:** the first valid instruction after a load appears 2 cycles after `load_req` falls.
- **Write timing:** loader writes take effect on the clock edge where `load_gnt`=1 and `load_we`=1. A write attempted in the request cycle before grant is dropped.
- **Simultaneous events:** `load_req` and a branch in the same cycle: the load wins and the branch is lost (the core restarts anyway).
- **Reset mid-load:** immediate return to IDLE; `load_gnt` drops asynchronously.
- **PC wrap:** 32'hFFFF_FFFC + 4 = 0. Only `ADDR_W` bits are driven to memory, so the address aliases.

## Structure
- **Shared package:** state enum (IDLE, RUN, LOAD, RESTART), `RESET_PC`, `ADDR_W`, instruction width 32.
- **Sub-module `next_pc_logic`:** combinational priority mux and adders. The FSM, PC register and port mux stay in the top. The memory instance stays outside this block.

## Test plan
- **Reset and run:** reset, then run 4 cycles with no branch → `pc` = 0, 4, 8, C; `mem_addr` = 1, 2, 3, 4 one cycle ahead; `instr_valid`=1 from cycle 1.
- **Taken branch:** at `pc`=8, `branch_offset`=0x10 with `zero`=1 → next `pc`=0x18. With `zero`=0 → 0xC.
- **Jump priority:** `jump`=1 with `jump_target`=0x41 and a taken branch in the same cycle → `pc`=0x40.
- **Stall:** hold `stall` for 3 cycles at `pc`=0xC → `pc` and `instr` unchanged, `mem_addr`=3. Release → `pc`=0x10.
- **Load cycle:** assert `load_req`, write words 0..3 (data 0xA0..0xA3), then drop `load_req`:
  - `load_gnt` 1 cycle late;
  - `mem_we` only while granted;
  - after 2 cycles, `pc`=0 and `instr`=0xA0.
- **Async reset mid-load:** assert `reset` mid-LOAD → `load_gnt`=0 and `mem_we`=0 immediately. After release, fetch resumes from `RESET_PC`.

Source files
------------

// File: rtl/fetch_controller_pkg.sv
// Shared constants for the instruction-fetch controller.
package fetch_controller_pkg;

  localparam int unsigned INSTR_W   = 32;
  localparam int unsigned FC_ADDR_W = 14;
  localparam logic [INSTR_W-1:0] FC_RESET_PC = 32'h0000_0000;

  // Fetch sequencer states
  localparam int unsigned STATE_W = 2;
  localparam logic [STATE_W-1:0] ST_IDLE    = 2'd0;
  localparam logic [STATE_W-1:0] ST_RUN     = 2'd1;
  localparam logic [STATE_W-1:0] ST_LOAD    = 2'd2;
  localparam logic [STATE_W-1:0] ST_RESTART = 2'd3;

endpackage

// File: rtl/fetch_controller_if.sv
// Instruction-memory port plus the program-loader handshake that shares it.
interface fetch_controller_if #(
  parameter int unsigned ADDR_W = fetch_controller_pkg::FC_ADDR_W
);

  localparam int unsigned DATA_W = fetch_controller_pkg::INSTR_W;

  logic              load_req;
  logic              load_we;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic              load_gnt;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Fetch controller side: owns the memory port, grants the loader
  modport master (
    input  load_req, load_we, load_addr, load_data, mem_rdata,
    output load_gnt, mem_addr, mem_we, mem_wdata
  );

  // Loader and memory side
  modport slave (
    output load_req, load_we, load_addr, load_data, mem_rdata,
    input  load_gnt, mem_addr, mem_we, mem_wdata
  );

endinterface

// File: rtl/fetch_controller_next_pc_logic.sv
// Next-PC selection: stall > jump > taken branch > sequential, word aligned.
module fetch_controller_next_pc_logic
  import fetch_controller_pkg::*;
(
  input  logic [INSTR_W-1:0] pc,
  input  logic               stall,
  input  logic               jump,
  input  logic               branch,
  input  logic               zero,
  input  logic [INSTR_W-1:0] jump_target,
  input  logic [INSTR_W-1:0] branch_offset,
  output logic [INSTR_W-1:0] next_pc_c
);

  localparam logic [INSTR_W-1:0] ALIGN_MASK = ~INSTR_W'(3);

  logic [INSTR_W-1:0] seq_pc_c;
  logic [INSTR_W-1:0] br_pc_c;
  logic [INSTR_W-1:0] raw_pc_c;

  assign seq_pc_c = pc + INSTR_W'(4);
  assign br_pc_c  = pc + branch_offset;

  // Priority mux of the candidate targets
  always_comb begin
    raw_pc_c = seq_pc_c;
    if (stall)
      raw_pc_c = pc;
    else if (jump)
      raw_pc_c = jump_target;
    else if (branch && zero)
      raw_pc_c = br_pc_c;
  end

  assign next_pc_c = raw_pc_c & ALIGN_MASK;

endmodule

// File: rtl/fetch_controller.sv
// Fetch sequencer: PC register, memory-port arbitration between core and loader.
module fetch_controller
  import fetch_controller_pkg::*;
#(
  parameter int unsigned        ADDR_W   = FC_ADDR_W,
  parameter logic [INSTR_W-1:0] RESET_PC = FC_RESET_PC
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               branch,
  input  logic               zero,
  input  logic [INSTR_W-1:0] branch_offset,
  input  logic               jump,
  input  logic [INSTR_W-1:0] jump_target,
  fetch_controller_if.master bus,
  output logic [INSTR_W-1:0] pc,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid
);

  localparam logic [ADDR_W-1:0] RESET_WORD = RESET_PC[ADDR_W+1:2];

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  logic [INSTR_W-1:0] pc_d;
  logic [INSTR_W-1:0] next_pc_c;

  logic [ADDR_W-1:0]  mem_addr_c;
  logic               mem_we_c;
  logic [INSTR_W-1:0] mem_wdata_c;
  logic               load_gnt_c;
  logic               instr_valid_c;

  fetch_controller_next_pc_logic u_next_pc (
    .pc            (pc),
    .stall         (stall),
    .jump          (jump),
    .branch        (branch),
    .zero          (zero),
    .jump_target   (jump_target),
    .branch_offset (branch_offset),
    .next_pc_c     (next_pc_c)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  // Program counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      pc <= RESET_PC;
    else
      pc <= pc_d;
  end

  // Next state, next PC and memory-port mux; the loader owns the port only in LOAD
  always_comb begin
    state_d       = state_q;
    pc_d          = pc;
    mem_addr_c    = RESET_WORD;
    mem_we_c      = 1'b0;
    mem_wdata_c   = '0;
    load_gnt_c    = 1'b0;
    instr_valid_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        pc_d    = RESET_PC;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        instr_valid_c = 1'b1;
        mem_addr_c    = next_pc_c[ADDR_W+1:2];
        if (bus.load_req)
          state_d = ST_LOAD;
        else
          pc_d = next_pc_c;
      end
      ST_LOAD: begin
        load_gnt_c  = 1'b1;
        mem_addr_c  = bus.load_addr;
        mem_we_c    = bus.load_we;
        mem_wdata_c = bus.load_data;
        if (!bus.load_req)
          state_d = ST_RESTART;
      end
      ST_RESTART: begin
        pc_d    = RESET_PC;
        state_d = bus.load_req ? ST_LOAD : ST_RUN;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_we    = mem_we_c;
  assign bus.mem_wdata = mem_wdata_c;
  assign bus.load_gnt  = load_gnt_c;
  assign instr_valid   = instr_valid_c;
  assign instr         = bus.mem_rdata;

endmodule

// File: tb/tb_fetch_controller.sv
// Randomized and directed check of fetch_controller against a behavioural model.
module tb_fetch_controller;
  import fetch_controller_pkg::*;

  localparam int unsigned AW    = FC_ADDR_W;
  localparam int unsigned DEPTH = 1 << AW;
  localparam logic [31:0] RPC   = FC_RESET_PC;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        branch = 1'b0;
  logic        zero = 1'b0;
  logic        jump = 1'b0;
  logic [31:0] branch_offset = '0;
  logic [31:0] jump_target = '0;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        instr_valid;

  int n_cmp = 0;
  int n_bad = 0;
  bit loading = 1'b0;

  fetch_controller_if #(.ADDR_W(AW)) bus ();

  fetch_controller #(.ADDR_W(AW), .RESET_PC(RPC)) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch        (branch),
    .zero          (zero),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_target   (jump_target),
    .bus           (bus),
    .pc            (pc),
    .instr         (instr),
    .instr_valid   (instr_valid)
  );

  always #5 clk = ~clk;

  // Instruction memory: synchronous read, one cycle latency
  logic [31:0] mem [DEPTH];
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  function automatic logic [31:0] pat(input int i);
    return 32'(i) * 32'h9E37_79B1 ^ 32'h0BAD_F00D;
  endfunction

  function automatic logic [AW-1:0] word(input logic [31:0] a);
    return a[AW+1:2];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the port, the architectural PC and memory contents
  bit          m_run, m_gnt, m_rst;
  logic [31:0] m_pc;
  logic [31:0] shadow [DEPTH];

  function automatic logic [31:0] model_npc();
    if (stall) return m_pc;
    if (jump) return {jump_target[31:2], 2'b00};
    if (branch && zero) return {32'(m_pc + branch_offset) >> 2, 2'b00};
    return m_pc + 32'd4;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_run <= 1'b0; m_gnt <= 1'b0; m_rst <= 1'b0; m_pc <= RPC;
    end else if (m_run) begin
      if (bus.load_req) begin m_run <= 1'b0; m_gnt <= 1'b1; end
      else m_pc <= model_npc();
    end else if (m_gnt) begin
      if (bus.load_we) shadow[bus.load_addr] <= bus.load_data;
      if (!bus.load_req) begin m_gnt <= 1'b0; m_rst <= 1'b1; end
    end else if (m_rst) begin
      m_rst <= 1'b0;
      m_pc  <= RPC;
      if (bus.load_req) m_gnt <= 1'b1; else m_run <= 1'b1;
    end else begin
      m_run <= 1'b1;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (!reset) begin
      chk("cmp_valid", 32'(instr_valid), 32'(m_run));
      chk("cmp_gnt", 32'(bus.load_gnt), 32'(m_gnt));
      chk("cmp_we", 32'(bus.mem_we), 32'(m_gnt && bus.load_we));
      chk("cmp_wdata", bus.mem_wdata, m_gnt ? bus.load_data : 32'd0);
      chk("cmp_addr", 32'(bus.mem_addr),
          32'(m_gnt ? bus.load_addr : (m_run ? word(model_npc()) : word(RPC))));
      chk("cmp_pc", pc, m_pc);
      if (m_run) chk("cmp_instr", instr, shadow[word(m_pc)]);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input logic [31:0] a);
    jump = 1'b1;
    jump_target = a;
    cyc();
    jump = 1'b0;
  endtask

  initial begin
    bus.load_req = 1'b0;
    bus.load_we = 1'b0;
    bus.load_addr = '0;
    bus.load_data = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem[i] <= pat(i);
      shadow[i] <= pat(i);
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", pc, RPC);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_gnt", 32'(bus.load_gnt), 32'd0);
    chk("rst_we", 32'(bus.mem_we), 32'd0);
    chk("rst_wdata", bus.mem_wdata, 32'd0);
    chk("rst_addr", 32'(bus.mem_addr), 32'd0);
    reset = 1'b0;
    #1 chk("idle_addr", 32'(bus.mem_addr), 32'd0);
    cyc();

    // Sequential fetch
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("run_pc", pc, 32'(4 * k));
      chk("run_addr", 32'(bus.mem_addr), 32'(k + 1));
      chk("run_valid", 32'(instr_valid), 32'd1);
      chk("run_instr", instr, pat(k));
      cyc();
    end

    // Taken and not-taken branch from pc=8
    goto(32'h8);
    branch = 1'b1; zero = 1'b1; branch_offset = 32'h10;
    #1 chk("br_addr", 32'(bus.mem_addr), 32'h6);
    cyc();
    branch = 1'b0;
    #1 chk("br_taken_pc", pc, 32'h18);
    chk("br_taken_instr", instr, pat(6));
    goto(32'h8);
    branch = 1'b1; zero = 1'b0;
    cyc();
    branch = 1'b0;
    #1 chk("br_not_pc", pc, 32'hC);

    // Jump beats a taken branch, low bits cleared
    jump = 1'b1; jump_target = 32'h41; branch = 1'b1; zero = 1'b1; branch_offset = 32'h100;
    cyc();
    jump = 1'b0; branch = 1'b0;
    #1 chk("jmp_pc", pc, 32'h40);

    // Stall holds pc and instr
    goto(32'hC);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_pc", pc, 32'hC);
      chk("stall_addr", 32'(bus.mem_addr), 32'd3);
      chk("stall_instr", instr, pat(3));
      cyc();
    end
    stall = 1'b0;
    cyc();
    #1 chk("unstall_pc", pc, 32'h10);

    // Load words 0..3; write in the request cycle must be dropped
    bus.load_req = 1'b1; bus.load_we = 1'b1; bus.load_addr = 14'd7; bus.load_data = 32'hDEAD;
    #1;
    chk("ld_req_gnt", 32'(bus.load_gnt), 32'd0);
    chk("ld_req_we", 32'(bus.mem_we), 32'd0);
    cyc();
    for (int k = 0; k < 4; k++) begin
      bus.load_addr = AW'(k);
      bus.load_data = 32'hA0 + 32'(k);
      #1;
      chk("ld_gnt", 32'(bus.load_gnt), 32'd1);
      chk("ld_we", 32'(bus.mem_we), 32'd1);
      chk("ld_addr", 32'(bus.mem_addr), 32'(k));
      chk("ld_valid", 32'(instr_valid), 32'd0);
      cyc();
    end
    bus.load_req = 1'b0; bus.load_we = 1'b0;
    #1 chk("ld_exit_gnt", 32'(bus.load_gnt), 32'd1);
    cyc();
    #1;
    chk("restart_gnt", 32'(bus.load_gnt), 32'd0);
    chk("restart_valid", 32'(instr_valid), 32'd0);
    chk("restart_addr", 32'(bus.mem_addr), 32'd0);
    cyc();
    #1;
    chk("post_ld_pc", pc, 32'h0);
    chk("post_ld_instr", instr, 32'hA0);
    chk("post_ld_valid", 32'(instr_valid), 32'd1);
    goto(32'h1C);
    #1 chk("dropped_wr", instr, pat(7));
    goto(32'h4);
    #1 chk("loaded_w1", instr, 32'hA1);

    // Asynchronous reset in the middle of a load
    bus.load_req = 1'b1;
    cyc();
    bus.load_we = 1'b1; bus.load_addr = 14'd20; bus.load_data = 32'h55;
    #1 chk("mid_ld_we", 32'(bus.mem_we), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("arst_gnt", 32'(bus.load_gnt), 32'd0);
    chk("arst_we", 32'(bus.mem_we), 32'd0);
    cyc();
    reset = 1'b0; bus.load_req = 1'b0; bus.load_we = 1'b0;
    cyc();
    #1;
    chk("arst_pc", pc, RPC);
    chk("arst_valid", 32'(instr_valid), 32'd1);
    chk("arst_instr", instr, 32'hA0);
    chk("arst_nowr", shadow[20], pat(20));

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      stall = ($urandom_range(0, 4) == 0);
      jump = ($urandom_range(0, 7) == 0);
      branch = ($urandom_range(0, 3) == 0);
      zero = 1'($urandom_range(0, 1));
      branch_offset = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 64)) - 32'd32;
      jump_target = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 255));
      if (loading) loading = ($urandom_range(0, 7) != 0);
      else loading = ($urandom_range(0, 49) == 0);
      bus.load_req = loading;
      bus.load_we = 1'($urandom_range(0, 1));
      bus.load_addr = ($urandom_range(0, 7) == 0) ? AW'($urandom()) : AW'($urandom_range(0, 63));
      bus.load_data = $urandom();
      if ($urandom_range(0, 699) == 0) begin
        #1 reset = 1'b1;
        cyc();
        reset = 1'b0;
        loading = 1'b0;
        bus.load_req = 1'b0;
      end else begin
        cyc();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
